// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: mode encodings and FSM state type shared by the universal shift register
package shift_reg_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROL   = 3'b100;
    localparam logic [2:0] MODE_ROR   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Only the shift/rotate modes are worth repeating in a burst
    function automatic logic is_burst_mode(input logic [2:0] mode);
        return (mode >= MODE_SHL) && (mode <= MODE_ASR);
    endfunction

endpackage

// File: rtl/shift_reg_univ_if.sv
// shift_reg_univ_if: control, data and status bundle; q_par exists only with SHIFT_REG_PARITY_EN
interface shift_reg_univ_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] par_in;
    logic             ser_in_l;
    logic             ser_in_r;
    logic             start;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] q;
    logic             ser_out_l;
    logic             ser_out_r;
    logic             busy;
    logic             done;
`ifdef SHIFT_REG_PARITY_EN
    logic             q_par;

    modport master (
        output en, mode, par_in, ser_in_l, ser_in_r, start, cnt,
        input  q, ser_out_l, ser_out_r, busy, done, q_par
    );

    modport slave (
        input  en, mode, par_in, ser_in_l, ser_in_r, start, cnt,
        output q, ser_out_l, ser_out_r, busy, done, q_par
    );
`else
    modport master (
        output en, mode, par_in, ser_in_l, ser_in_r, start, cnt,
        input  q, ser_out_l, ser_out_r, busy, done
    );

    modport slave (
        input  en, mode, par_in, ser_in_l, ser_in_r, start, cnt,
        output q, ser_out_l, ser_out_r, busy, done
    );
`endif
endinterface

// File: rtl/shift_reg_step.sv
// shift_reg_step: one-step next value of the register for a given mode
module shift_reg_step
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] par_in_i,
    input  logic             ser_in_l_i,
    input  logic             ser_in_r_i,
    output logic [WIDTH-1:0] q_next_o
);

    // Pure next-value decode shared by single-step and burst paths
    always_comb begin
        q_next_o = q_i;
        case (mode_i)
            MODE_LOAD:  q_next_o = par_in_i;
            MODE_SHL:   q_next_o = {q_i[WIDTH-2:0], ser_in_r_i};
            MODE_SHR:   q_next_o = {ser_in_l_i, q_i[WIDTH-1:1]};
            MODE_ROL:   q_next_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
            MODE_ROR:   q_next_o = {q_i[0], q_i[WIDTH-1:1]};
            MODE_ASR:   q_next_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
            MODE_CLEAR: q_next_o = '0;
            default:    q_next_o = q_i;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// shift_reg_univ: universal shift register with burst engine; SHIFT_REG_PARITY_EN adds registered q_par
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    shift_reg_univ_if.slave  bus
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] q_step;
    logic             in_shift;

    assign in_shift = (state_q == ST_SHIFT);

    // During a burst the latched mode drives the step; otherwise the live mode does
    shift_reg_step #(.WIDTH(WIDTH)) u_step (
        .q_i        (q_q),
        .mode_i     (in_shift ? mode_q : bus.mode),
        .par_in_i   (bus.par_in),
        .ser_in_l_i (bus.ser_in_l),
        .ser_in_r_i (bus.ser_in_r),
        .q_next_o   (q_step)
    );

    // Next-state and datapath decisions; start wins over en, DONE always returns to IDLE
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        q_d     = q_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (is_burst_mode(bus.mode) && (bus.cnt != '0)) begin
                        mode_d  = bus.mode;
                        count_d = bus.cnt;
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (bus.en) begin
                    q_d = q_step;
                end
            end
            ST_SHIFT: begin
                q_d     = q_step;
                count_d = count_q - CNT_W'(1);
                state_d = (count_q == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State, counter, latched mode and data register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            mode_q  <= MODE_HOLD;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
        end
    end

    assign bus.q         = q_q;
    assign bus.ser_out_l = q_q[WIDTH-1];
    assign bus.ser_out_r = q_q[0];
    assign bus.busy      = in_shift;
    assign bus.done      = (state_q == ST_DONE);

`ifdef SHIFT_REG_PARITY_EN
    logic q_par_q;

    // Parity follows the value q is about to take so both change on the same edge
    always_ff @(posedge clk) begin
        if (reset) q_par_q <= 1'b0;
        else       q_par_q <= ^q_d;
    end

    assign bus.q_par = q_par_q;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// tb_shift_reg_univ: directed vector table plus randomized run against a behavioural model
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    shift_reg_univ_if #(.WIDTH(W), .CNT_W(CW)) bus ();
    shift_reg_univ #(.WIDTH(W), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic          rst;
        logic          en;
        logic [2:0]    mode;
        logic [W-1:0]  par;
        logic          sl;
        logic          sr;
        logic          start;
        logic [CW-1:0] cnt;
        logic [W-1:0]  eq;
        logic          ebusy;
        logic          edone;
    } vec_t;

    vec_t vecs[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check_q(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic e, input logic [2:0] m, input logic [W-1:0] p,
                         input logic l, input logic s, input logic st, input logic [CW-1:0] c);
        reset        = r;
        bus.en       = e;
        bus.mode     = m;
        bus.par_in   = p;
        bus.ser_in_l = l;
        bus.ser_in_r = s;
        bus.start    = st;
        bus.cnt      = c;
    endtask

    task automatic add(input logic r, input logic e, input logic [2:0] m, input logic [W-1:0] p,
                       input logic l, input logic s, input logic st, input logic [CW-1:0] c,
                       input logic [W-1:0] eq, input logic eb, input logic ed);
        vecs.push_back('{r, e, m, p, l, s, st, c, eq, eb, ed});
    endtask

    function automatic logic [W-1:0] model_step(input logic [W-1:0] q, input logic [2:0] m,
                                                input logic [W-1:0] p, input logic l, input logic s);
        logic [W-1:0] r;
        case (m)
            3'd1:    r = p;
            3'd2:    r = (q << 1) | W'(s);
            3'd3:    r = (q >> 1) | (W'(l) << (W - 1));
            3'd4:    r = (q << 1) | (q >> (W - 1));
            3'd5:    r = (q >> 1) | (q << (W - 1));
            3'd6:    r = W'($signed(q) >>> 1);
            3'd7:    r = '0;
            default: r = q;
        endcase
        return r;
    endfunction

    logic [W-1:0]  mq;
    int            mleft;
    logic [2:0]    mmode;
    logic          mdone;
    logic          r, e, l, s, st;
    logic [2:0]    md;
    logic [W-1:0]  p;
    logic [CW-1:0] c;

    initial begin
        drive(1, 0, 3'd0, '0, 0, 0, 0, '0);
        //   rst en mode   par    sl sr st cnt    q      busy done
        add(1, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
        add(0, 1, 3'd1, 8'hA5, 0, 0, 0, 4'd0, 8'hA5, 0, 0);
        add(1, 1, 3'd1, 8'hFF, 0, 0, 0, 4'd0, 8'h00, 0, 0);
        add(0, 1, 3'd1, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
        add(0, 1, 3'd4, 8'h00, 0, 0, 0, 4'd0, 8'h03, 0, 0);
        add(0, 1, 3'd1, 8'h81, 0, 0, 0, 4'd0, 8'h81, 0, 0);
        add(0, 1, 3'd5, 8'h00, 0, 0, 0, 4'd0, 8'hC0, 0, 0);
        add(0, 1, 3'd1, 8'h80, 0, 0, 0, 4'd0, 8'h80, 0, 0);
        add(0, 1, 3'd6, 8'h00, 0, 0, 0, 4'd0, 8'hC0, 0, 0);
        add(0, 1, 3'd7, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
        add(0, 1, 3'd2, 8'h00, 0, 1, 0, 4'd0, 8'h01, 0, 0);
        add(0, 0, 3'd2, 8'h00, 0, 0, 1, 4'd3, 8'h01, 1, 0);
        add(0, 1, 3'd1, 8'hFF, 0, 0, 0, 4'd0, 8'h02, 1, 0);
        add(0, 1, 3'd7, 8'hFF, 0, 0, 1, 4'd9, 8'h04, 1, 0);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 1);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 0);
        add(0, 0, 3'd2, 8'h00, 0, 0, 1, 4'd0, 8'h08, 0, 1);
        add(0, 1, 3'd2, 8'h00, 0, 1, 1, 4'd2, 8'h08, 0, 0);
        add(0, 0, 3'd1, 8'h55, 0, 0, 1, 4'd5, 8'h08, 0, 1);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h08, 0, 0);
        add(0, 1, 3'd1, 8'h96, 0, 0, 0, 4'd0, 8'h96, 0, 0);
        add(0, 0, 3'd5, 8'h00, 0, 0, 1, 4'd15, 8'h96, 1, 0);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h4B, 1, 0);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hA5, 1, 0);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'hD2, 1, 0);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h69, 1, 0);
        add(1, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
        add(0, 0, 3'd0, 8'h00, 0, 0, 0, 4'd0, 8'h00, 0, 0);
        add(0, 1, 3'd1, 8'h07, 0, 0, 0, 4'd0, 8'h07, 0, 0);
        add(0, 1, 3'd2, 8'h00, 0, 0, 0, 4'd0, 8'h0E, 0, 0);
        add(0, 1, 3'd1, 8'h03, 0, 0, 0, 4'd0, 8'h03, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].par,
                  vecs[i].sl, vecs[i].sr, vecs[i].start, vecs[i].cnt);
            @(posedge clk);
            #1;
            check_q($sformatf("vec%0d_q", i), bus.q, vecs[i].eq);
            check_b($sformatf("vec%0d_busy", i), bus.busy, vecs[i].ebusy);
            check_b($sformatf("vec%0d_done", i), bus.done, vecs[i].edone);
`ifdef SHIFT_REG_PARITY_EN
            check_b($sformatf("vec%0d_par", i), bus.q_par, ^vecs[i].eq);
`endif
        end

        mq = '0; mleft = 0; mmode = 3'd0; mdone = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            r  = (i == 0) || ($urandom_range(63) == 0);
            e  = 1'($urandom_range(1));
            md = 3'($urandom_range(7));
            p  = W'($urandom);
            l  = 1'($urandom_range(1));
            s  = 1'($urandom_range(1));
            st = ($urandom_range(5) == 0);
            c  = CW'($urandom_range(15));
            drive(r, e, md, p, l, s, st, c);
            if (r) begin
                mq = '0; mleft = 0; mdone = 1'b0;
            end else if (mdone) begin
                mdone = 1'b0;
            end else if (mleft > 0) begin
                mq = model_step(mq, mmode, p, l, s);
                mleft--;
                mdone = (mleft == 0);
            end else if (st) begin
                if (md >= 3'd2 && md <= 3'd6 && c != 0) begin
                    mmode = md;
                    mleft = int'(c);
                end else begin
                    mdone = 1'b1;
                end
            end else if (e) begin
                mq = model_step(mq, md, p, l, s);
            end
            @(posedge clk);
            #1;
            check_q($sformatf("rnd%0d_q", i), bus.q, mq);
            check_b($sformatf("rnd%0d_busy", i), bus.busy, mleft > 0);
            check_b($sformatf("rnd%0d_done", i), bus.done, mdone);
            check_b($sformatf("rnd%0d_sol", i), bus.ser_out_l, mq[W-1]);
            check_b($sformatf("rnd%0d_sor", i), bus.ser_out_r, mq[0]);
`ifdef SHIFT_REG_PARITY_EN
            check_b($sformatf("rnd%0d_par", i), bus.q_par, ^mq);
`endif
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
